// File: rtl/mc_pkg.sv
// Shared constants and FSM encoding for the MC host controller.
package mc_pkg;

   localparam int FRAME_LEN   = 256;
   localparam int TIMEOUT_CYC = 2047;
   localparam int SAMPLE_W    = 16;
   localparam int IDX_W       = 8;
   localparam int LAT_W       = 11;
   localparam int DEPTH       = 1 << IDX_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mc_host_ram.sv
// 256-entry single-write-port RAM with a registered, clearable read port.
module mc_host_ram
   import mc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the array has no reset so it maps onto RAM macros; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // rd_en low forces zero so the register can drive a bus that must idle at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata <= '0;
      else        rdata <= rd_en ? mem[raddr] : '0;
   end

endmodule

// File: rtl/mc_host.sv
// Frame host for an MC block: streams a stored sample frame out, captures results, measures latency.
module mc_host
   import mc_pkg::*;
#(
   parameter int FRAME_LEN   = mc_pkg::FRAME_LEN,
   parameter int TIMEOUT_CYC = mc_pkg::TIMEOUT_CYC
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       wr_en,
   input  logic        [IDX_W-1:0]    wr_addr,
   input  logic signed [SAMPLE_W-1:0] wr_x_real,
   input  logic signed [SAMPLE_W-1:0] wr_delta_real,
   input  logic signed [SAMPLE_W-1:0] wr_delta_img,
   output logic                       mc_in_valid,
   output logic signed [SAMPLE_W-1:0] mc_x_real,
   output logic signed [SAMPLE_W-1:0] mc_delta_real,
   output logic signed [SAMPLE_W-1:0] mc_delta_img,
   input  logic                       mc_out_valid,
   input  logic signed [SAMPLE_W-1:0] mc_y_real,
   input  logic signed [SAMPLE_W-1:0] mc_y_img,
   input  logic        [IDX_W-1:0]    rd_addr,
   output logic signed [SAMPLE_W-1:0] rd_y_real,
   output logic signed [SAMPLE_W-1:0] rd_y_img,
   output logic                       busy,
   output logic                       done,
   output logic                       timeout,
   output logic        [LAT_W-1:0]    lat_cycles
);

   state_t             state, state_nx;
   logic [IDX_W-1:0]   send_idx, send_addr;
   logic [IDX_W:0]     cap_cnt;
   logic [LAT_W-1:0]   elapsed;
   logic               send_nx, tmo_set;
   logic               last_send, cap_full, tmo_hit, capture, active;

   assign active    = (state == SEND) || (state == WAIT);
   assign last_send = (send_idx == IDX_W'(FRAME_LEN - 1));
   assign cap_full  = (cap_cnt == (IDX_W + 1)'(FRAME_LEN));
   assign tmo_hit   = (elapsed == LAT_W'(TIMEOUT_CYC - 1));
   assign capture   = active && mc_out_valid && !cap_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // send_nx/send_addr describe the next cycle's sample so the RAM read register can be the output register.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nx  = state;
      send_nx   = 1'b0;
      send_addr = send_idx + IDX_W'(1);
      tmo_set   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx  = SEND;
               send_nx   = 1'b1;
               send_addr = '0;
            end
         end
         SEND: begin
            if (tmo_hit) begin
               state_nx = DONE;
               tmo_set  = 1'b1;
            end else if (last_send) begin
               state_nx = WAIT;
            end else begin
               send_nx = 1'b1;
            end
         end
         WAIT: begin
            if (cap_full) begin
               state_nx = DONE;
            end else if (tmo_hit) begin
               state_nx = DONE;
               tmo_set  = 1'b1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // elapsed reads 0 in the first mc_in_valid cycle because it is cleared on the start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mc_in_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         send_idx    <= '0;
         cap_cnt     <= '0;
         elapsed     <= '0;
         lat_cycles  <= '0;
      end else begin
         mc_in_valid <= send_nx;
         busy        <= (state_nx != IDLE);
         done        <= (state_nx == DONE);
         if (send_nx) send_idx <= send_addr;
         if (state == IDLE && start) begin
            cap_cnt <= '0;
            elapsed <= '0;
            timeout <= 1'b0;
         end else begin
            if (busy && elapsed != '1) elapsed <= elapsed + LAT_W'(1);
            if (capture) begin
               cap_cnt <= cap_cnt + (IDX_W + 1)'(1);
               if (cap_cnt == '0) lat_cycles <= elapsed;
            end
            if (tmo_set) timeout <= 1'b1;
         end
      end
   end

   mc_host_ram #(.WIDTH(3 * SAMPLE_W)) u_sample_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en && (state == IDLE)),
      .waddr (wr_addr),
      .wdata ({wr_x_real, wr_delta_real, wr_delta_img}),
      .rd_en (send_nx),
      .raddr (send_addr),
      .rdata ({mc_x_real, mc_delta_real, mc_delta_img})
   );

   mc_host_ram #(.WIDTH(2 * SAMPLE_W)) u_result_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (capture),
      .waddr (cap_cnt[IDX_W-1:0]),
      .wdata ({mc_y_real, mc_y_img}),
      .rd_en (1'b1),
      .raddr (rd_addr),
      .rdata ({rd_y_real, rd_y_img})
   );

endmodule

// File: tb/tb_mc_host.sv
// Directed bench for mc_host: a cycle-stepped MC model with sample and result scoreboards.
module tb_mc_host;
   import mc_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               wr_en = 1'b0;
   logic        [7:0]  wr_addr = '0;
   logic signed [15:0] wr_x_real = '0, wr_delta_real = '0, wr_delta_img = '0;
   logic               mc_in_valid;
   logic signed [15:0] mc_x_real, mc_delta_real, mc_delta_img;
   logic               mc_out_valid = 1'b0;
   logic signed [15:0] mc_y_real = '0, mc_y_img = '0;
   logic        [7:0]  rd_addr = '0;
   logic signed [15:0] rd_y_real, rd_y_img;
   logic               busy, done, timeout;
   logic        [10:0] lat_cycles;

   int total = 0;
   int bad   = 0;

   logic [47:0] samp [256];
   logic [47:0] sq [$];
   logic [31:0] rq [$];

   always #5 clk = ~clk;

   mc_host dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_x_real     (wr_x_real),
      .wr_delta_real (wr_delta_real),
      .wr_delta_img  (wr_delta_img),
      .mc_in_valid   (mc_in_valid),
      .mc_x_real     (mc_x_real),
      .mc_delta_real (mc_delta_real),
      .mc_delta_img  (mc_delta_img),
      .mc_out_valid  (mc_out_valid),
      .mc_y_real     (mc_y_real),
      .mc_y_img      (mc_y_img),
      .rd_addr       (rd_addr),
      .rd_y_real     (rd_y_real),
      .rd_y_img      (rd_y_img),
      .busy          (busy),
      .done          (done),
      .timeout       (timeout),
      .lat_cycles    (lat_cycles)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_samples();
      for (int i = 0; i < 256; i++) begin
         wr_en         = 1'b1;
         wr_addr       = 8'(i);
         wr_x_real     = samp[i][47:32];
         wr_delta_real = samp[i][31:16];
         wr_delta_img  = samp[i][15:0];
         @(posedge clk); #1;
      end
      wr_en = 1'b0;
   endtask

   // Pulses start, streams the frame, plays the MC model and checks the outcome plus readback.
   task automatic run_frame(input int lat, input int n_out, input bit gaps, input bit exp_tmo,
                            input int exp_done_t, input int exp_lat, input bit poke);
      int t = -1, sent = 0, emitted = 0, done_cnt = 0, done_t = -1, cyc = 0;
      bit saw_low = 1'b0, gap_err = 1'b0, finished = 1'b0;
      logic [47:0] e;
      for (int i = 0; i < 256; i++) sq.push_back(samp[i]);
      start = 1'b1;
      while (!finished && cyc < 4000) begin
         @(posedge clk); #1;
         cyc++;
         start = 1'b0;
         wr_en = 1'b0;
         if (cyc == 1) begin
            check("first_valid", mc_in_valid, 1);
            check("busy_on_start", busy, 1);
            check("tmo_cleared", timeout, 0);
         end
         if (t >= 0) t++;
         else if (mc_in_valid) t = 0;
         if (mc_in_valid) begin
            if (saw_low || sq.size() == 0) gap_err = 1'b1;
            else begin
               e = sq.pop_front();
               check("send_data", {mc_x_real, mc_delta_real, mc_delta_img}, e);
            end
            sent++;
            if (poke && sent == 50) begin
               start         = 1'b1;
               wr_en         = 1'b1;
               wr_addr       = 8'd5;
               wr_x_real     = 16'sh5A5A;
               wr_delta_real = 16'sh1234;
               wr_delta_img  = 16'sh4321;
            end
         end else begin
            if (t >= 0) saw_low = 1'b1;
            check("idle_data_zero", {mc_x_real, mc_delta_real, mc_delta_img}, 64'd0);
         end
         if (done) begin
            done_cnt++;
            if (done_t < 0) done_t = t;
            check("done_tmo", timeout, exp_tmo);
         end
         if (done_cnt > 0 && !busy) finished = 1'b1;
         mc_out_valid = 1'b0;
         mc_y_real    = '0;
         mc_y_img     = '0;
         if (!finished && t >= lat && emitted < n_out &&
             (!gaps || emitted == 0 || $urandom_range(0, 2) != 0)) begin
            mc_out_valid = 1'b1;
            mc_y_real    = 16'(emitted * 3 + 1);
            mc_y_img     = ~16'(emitted);
            if (emitted < 256) rq.push_back({mc_y_real, mc_y_img});
            emitted++;
         end
      end
      mc_out_valid = 1'b0;
      check("frame_finished", finished, 1);
      check("send_count", sent, 256);
      check("send_contig", gap_err, 0);
      check("done_once", done_cnt, 1);
      check("busy_idle", busy, 0);
      check("tmo_flag", timeout, exp_tmo);
      check("lat_cycles", lat_cycles, exp_lat);
      if (exp_done_t >= 0) check("done_time", done_t, exp_done_t);
      sq.delete();
      if (!exp_tmo) begin
         for (int i = 0; i < 256; i++) begin
            rd_addr = 8'(i);
            @(posedge clk); #1;
            if (rq.size() == 0) check("rd_y_missing", 1, 0);
            else check("rd_y", {rd_y_real, rd_y_img}, rq.pop_front());
         end
      end
      rq.delete();
   endtask

   initial begin
      int sent, cyc, done_seen;
      bit hit;

      #12;
      check("rst_in_valid", mc_in_valid, 0);
      check("rst_mc_data", {mc_x_real, mc_delta_real, mc_delta_img}, 64'd0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_timeout", timeout, 0);
      check("rst_lat", lat_cycles, 0);
      check("rst_rd_y", {rd_y_real, rd_y_img}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 256; i++) samp[i] = {16'(i), 16'h7FFF, 16'h0000};
      load_samples();

      // Fixed 535-cycle MC latency, contiguous results.
      run_frame(535, 256, 1'b0, 1'b0, -1, 535, 1'b0);
      // MC never answers: timeout at 2047, latency register holds its old value.
      run_frame(0, 0, 1'b0, 1'b1, 2047, 535, 1'b0);
      // Start and writes during SEND are ignored; results overlap the send phase.
      run_frame(20, 256, 1'b0, 1'b0, -1, 20, 1'b1);
      // Sample 5 must still carry the original word.
      run_frame(7, 256, 1'b0, 1'b0, -1, 7, 1'b0);

      // Abort a frame with reset while sample 100 is on the bus.
      sent = 0;
      cyc  = 0;
      hit  = 1'b0;
      start = 1'b1;
      while (!hit && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         start = 1'b0;
         if (mc_in_valid) begin
            if (sent == 100) hit = 1'b1;
            else sent++;
         end
      end
      check("pre_reset_reached", hit, 1);
      check("pre_reset_idx", mc_x_real, 100);
      #2 rst_n = 1'b0;
      #1;
      check("abort_in_valid", mc_in_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_data", mc_x_real, 0);
      check("abort_lat", lat_cycles, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done || busy || mc_in_valid) done_seen++;
      end
      check("abort_quiet", done_seen, 0);
      // Samples survive reset; the restarted frame begins at index 0.
      run_frame(3, 256, 1'b0, 1'b0, -1, 3, 1'b0);

      // Random samples, gappy results with four surplus outputs.
      for (int i = 0; i < 256; i++) samp[i] = 48'({$urandom, $urandom});
      load_samples();
      run_frame(40, 260, 1'b1, 1'b0, -1, 40, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mc_host.md
MC_HOST -- requirements
Module: mc_host

Interface
REQ-001 Parameter FRAME_LEN, 256, samples per frame sent and captured.
REQ-002 Parameter TIMEOUT_CYC, 2047, max cycles from first sent sample to last captured result.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle request to run one frame.
REQ-006 wr_en  input  1  load-port write strobe.
REQ-007 wr_addr  input  8  load-port sample index.
REQ-008 wr_x_real, wr_delta_real, wr_delta_img  input  16 each  signed sample words.
REQ-009 mc_in_valid  output  1  drives the MC block's in_valid.
REQ-010 mc_x_real, mc_delta_real, mc_delta_img  output  16 each  drive the MC block's sample inputs.
REQ-011 mc_out_valid  input  1  MC block's out_valid.
REQ-012 mc_y_real, mc_y_img  input  16 each  MC block's result samples.
REQ-013 rd_addr  input  8  result read index.
REQ-014 rd_y_real, rd_y_img  output  16 each  result words, registered.
REQ-015 busy  output  1  high from start accept until return to IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 timeout  output  1  sticky frame-failure flag.
REQ-018 lat_cycles  output  11  cycles from first mc_in_valid to first captured mc_out_valid.

Function
REQ-019 FSM states: IDLE, SEND, WAIT, DONE.
REQ-020 IDLE->SEND on start=1; start in any other state is ignored.
REQ-021 wr_en writes the sample RAM only in IDLE; writes in other states are dropped.
REQ-022 SEND: mc_in_valid high for exactly FRAME_LEN consecutive cycles, first high cycle is the cycle after start is sampled, index 0..FRAME_LEN-1 in order.
REQ-023 mc_* sample outputs are registered, carry RAM word [index] in the same cycle as mc_in_valid, and are 0 whenever mc_in_valid=0.
REQ-024 After the last sample, SEND->WAIT; mc_in_valid stays low for at least one cycle, never back-to-back frames.
REQ-025 In SEND and WAIT, each cycle with mc_out_valid=1 writes {mc_y_real, mc_y_img} to result[cap_cnt] and increments cap_cnt; gaps in mc_out_valid are tolerated.
REQ-026 mc_out_valid in IDLE or DONE is ignored; captures beyond FRAME_LEN are dropped.
REQ-027 lat_cycles: elapsed counter starts at 0 on the first mc_in_valid cycle, increments each cycle while busy, and is latched on the first capture of a frame; it saturates at 2047.
REQ-028 WAIT->DONE when cap_cnt reaches FRAME_LEN; timeout stays 0.
REQ-029 If the elapsed counter reaches TIMEOUT_CYC before FRAME_LEN captures, the FSM goes to DONE and sets timeout=1, from SEND or WAIT.
REQ-030 DONE lasts one cycle with done=1, then goes to IDLE.
REQ-031 timeout clears on the next accepted start; lat_cycles holds until the next frame's first capture.
REQ-032 rd_y_* = result[rd_addr] one cycle after rd_addr, in any state; reads during busy may return a mix of old and new frame data.
REQ-033 Capture and the final-sample send in the same cycle are both honoured.

Reset
REQ-034 rst_n low forces IDLE and sets mc_in_valid, mc_* data, busy, done, timeout, lat_cycles, rd_y_*, and all counters to 0 immediately.
REQ-035 Sample and result RAMs are not reset.
REQ-036 Reset mid-frame abandons the frame; no done pulse follows.

Structure
REQ-037 Shared package mc_pkg holds FRAME_LEN, TIMEOUT_CYC, the 16-bit sample width, the 8-bit index width, and the FSM state encoding.
REQ-038 A single sub-module mc_host_ram (256-entry, one write port, one registered read port, parameterised width) is instantiated twice: 48-bit for samples, 32-bit for results.

Verification
REQ-039 Load x_real[i]=i, delta_real[i]=16'h7FFF, delta_img[i]=0, pulse start -> exactly 256 mc_in_valid cycles carrying x_real 0..255 in order, then mc_in_valid low.
REQ-040 Model MC returning 256 out_valid cycles starting 535 cycles after the first in_valid -> lat_cycles=535, done pulses once, timeout=0, and reading rd_addr=0..255 returns captured data.
REQ-041 Model never asserts out_valid -> done plus timeout=1 exactly 2047 cycles after the first in_valid; the next start clears timeout.
REQ-042 Start pulsed and wr_en asserted during SEND -> no restart, and the sample RAM is unchanged on readback of the next frame.
REQ-043 rst_n dropped at sample 100 of SEND -> mc_in_valid and busy go 0 asynchronously, with no done pulse; a new start sends from index 0.
REQ-044 Model emits out_valid with random gaps, then 260 results -> only the first 256 are stored, and done pulses once.
